// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory boot loader.
package imem_pkg;

  localparam int unsigned LEN_W            = 16;
  localparam int unsigned BYTES_PER_WORD   = 4;
  localparam int unsigned MEM_SIZE_DEFAULT = 512;

  // Loader phases: two header bytes, data bytes, one write cycle, then a terminal state.
  typedef enum logic [2:0] {
    StHdr0  = 3'd0,
    StHdr1  = 3'd1,
    StData  = 3'd2,
    StWrite = 3'd3,
    StDone  = 3'd4,
    StErr   = 3'd5
  } state_t;

endpackage

// File: rtl/byte_word_packer.sv
// Packs a little-endian byte stream into 32-bit words: the first byte lands in [7:0].
module byte_word_packer
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        word_full
);

  localparam logic [1:0] CntLast = 2'(BYTES_PER_WORD - 1);

  logic [31:0] word_q;
  logic [1:0]  byte_cnt_q;

  // Word value including the byte being loaded now, so the 4th byte can be written at once.
  always_comb begin
    word_next = {byte_in, word_q[31:8]};
    word_full = (byte_cnt_q == CntLast);
  end

  // Shift register and byte counter; the counter wraps to 0 after the 4th byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q     <= '0;
      byte_cnt_q <= '0;
    end else if (clear) begin
      word_q     <= '0;
      byte_cnt_q <= '0;
    end else if (load) begin
      word_q     <= word_next;
      byte_cnt_q <= byte_cnt_q + 2'd1;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed image, writes it to instruction memory from word 0,
// and holds the CPU until the whole image has been written.
module imem_boot_loader
  import imem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_SIZE   = MEM_SIZE_DEFAULT,
  parameter int unsigned AW         = $clog2(MEM_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_byte,
  output logic                  rx_ready,
  input  logic                  reload,
  output logic                  mem_we,
  output logic [AW-1:0]         mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_err
);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q;
  logic [AW-1:0]    word_idx_q;
  logic [LEN_W-1:0] hdr_len;
  logic             hdr_bad;
  logic             last_word;
  logic             xfer;
  logic             pack_load;
  logic             pack_clear;
  logic [31:0]      word_next;
  logic             word_full;

  // Handshake, header check and last-word decode; reload suppresses any byte transfer.
  always_comb begin
    xfer       = rx_valid & rx_ready & ~reload;
    hdr_len    = {rx_byte, len_q[7:0]};
    hdr_bad    = (hdr_len == '0) || (hdr_len > LEN_W'(MEM_SIZE));
    last_word  = (LEN_W'(word_idx_q) == (len_q - LEN_W'(1)));
    pack_load  = xfer && (state_q == StData);
    pack_clear = reload || (xfer && (state_q == StHdr1));
  end

  byte_word_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (pack_clear),
    .load      (pack_load),
    .byte_in   (rx_byte),
    .word_next (word_next),
    .word_full (word_full)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StHdr0;
    else       state_q <= state_d;
  end

  // Next-state logic; reload overrides every state.
  always_comb begin
    state_d = state_q;
    if (reload) begin
      state_d = StHdr0;
    end else begin
      case (state_q)
        StHdr0:  if (xfer) state_d = StHdr1;
        StHdr1:  if (xfer) state_d = hdr_bad ? StErr : StData;
        StData:  if (xfer && word_full) state_d = StWrite;
        StWrite: state_d = last_word ? StDone : StData;
        StDone:  state_d = StDone;
        StErr:   state_d = StErr;
        default: state_d = StHdr0;
      endcase
    end
  end

  // rx_ready is decoded from state: only the write cycle stalls the byte stream.
  always_comb begin
    rx_ready = 1'b1;
    case (state_q)
      StWrite: rx_ready = 1'b0;
      default: rx_ready = 1'b1;
    endcase
  end

  // Header length and word address counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q      <= '0;
      word_idx_q <= '0;
    end else if (reload) begin
      len_q      <= '0;
      word_idx_q <= '0;
    end else begin
      if (xfer && (state_q == StHdr0)) len_q[7:0] <= rx_byte;
      if (xfer && (state_q == StHdr1)) begin
        len_q[15:8] <= rx_byte;
        word_idx_q  <= '0;
      end
      if ((state_q == StWrite) && !last_word) word_idx_q <= word_idx_q + AW'(1);
    end
  end

  // Registered outputs, derived from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      mem_we    <= (state_d == StWrite);
      cpu_hold  <= (state_d != StDone);
      load_done <= (state_d == StDone);
      load_err  <= (state_d == StErr);
      if (reload) begin
        mem_waddr <= '0;
        mem_wdata <= '0;
      end else if (pack_load && word_full) begin
        mem_waddr <= word_idx_q;
        mem_wdata <= DATA_WIDTH'(word_next);
      end
    end
  end

endmodule
